// File: rtl/dmem_access_pkg.sv
// Shared encodings for the data-memory access unit: access sizes, FSM states,
// byte-lane offsets and the request-decode helpers.
package dmem_access_pkg;

    // Access size encodings; 2'b11 is folded onto a word access.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Little-endian byte lanes within a word (addr[1:0]).
    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;

    // Halfword lanes: low half at offset 0, high half at offset 2.
    localparam logic [1:0] HALF_LO = 2'd0;
    localparam logic [1:0] HALF_HI = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STORE,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_RESP
    } state_e;

    // Collapse the reserved size code onto a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == SZ_BYTE || size == SZ_HALF) ? size : SZ_WORD;
    endfunction

    // Halfwords need an even address, words need a 4-byte-aligned address.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return offset[0];
            default: return offset != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// Request/response bus between the datapath and the access unit, plus the
// word-wide data-memory port the unit drives.
interface dmem_access_unit_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Datapath side
    logic          req;
    logic          wr;
    logic [1:0]    size;
    logic          uns;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ready;
    logic          done;
    logic [DW-1:0] rdata;
    logic          misaligned;

    // Data-memory side
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    // Environment: issues requests and plays the memory.
    modport master (
        output req, wr, size, uns, addr, wdata, mem_rd,
        input  ready, done, rdata, misaligned, mem_we, mem_a, mem_wd
    );

    // Access unit.
    modport slave (
        input  req, wr, size, uns, addr, wdata, mem_rd,
        output ready, done, rdata, misaligned, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/dmem_lane.sv
// Byte-lane logic: extract and extend a load from the memory word, and merge
// sub-word store data into a previously read word.
module dmem_lane
    import dmem_access_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [1:0]    size,
    input  logic          uns,
    input  logic [1:0]    offset,
    input  logic [DW-1:0] rd_word,
    input  logic [DW-1:0] merge_word,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] load_data,
    output logic [DW-1:0] store_word
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Load path: pick the addressed lane and sign- or zero-extend it.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        byte_sel  = rd_word[7:0];
        half_sel  = rd_word[15:0];
        load_data = rd_word;
        case (offset)
            LANE_B1: byte_sel = rd_word[15:8];
            LANE_B2: byte_sel = rd_word[23:16];
            LANE_B3: byte_sel = rd_word[31:24];
            default: byte_sel = rd_word[7:0];
        endcase
        if ((offset & HALF_HI) == HALF_HI) begin
            half_sel = rd_word[31:16];
        end
        case (size)
            SZ_BYTE: load_data = {{(DW-8){~uns & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{(DW-16){~uns & half_sel[15]}}, half_sel};
            default: load_data = rd_word;
        endcase
    end

    // Store path: replace only the addressed lane(s) of the read-back word.
    always_comb begin
        store_word = merge_word;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    LANE_B0: store_word[7:0]   = wdata[7:0];
                    LANE_B1: store_word[15:8]  = wdata[7:0];
                    LANE_B2: store_word[23:16] = wdata[7:0];
                    default: store_word[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if ((offset & HALF_HI) == HALF_LO) store_word[15:0]  = wdata[15:0];
                else                               store_word[31:16] = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end
endmodule

// File: rtl/dmem_access_unit.sv
// Data-memory access controller: byte/half/word loads with extension, word
// stores directly, sub-word stores as read-modify-write, misaligned rejection.
module dmem_access_unit
    import dmem_access_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input logic               clk,
    input logic               reset,
    dmem_access_unit_if.slave bus
);
    state_e        state_q, state_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [1:0]    off_q, off_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          err_q, err_d;
    logic [DW-1:0] merge_q, merge_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] mem_a_q, mem_a_d;

    logic [1:0]    req_size;
    logic          req_err;
    logic [DW-1:0] load_data;
    logic [DW-1:0] store_word;
    logic          writing;

    assign req_size = norm_size(bus.size);
    assign req_err  = is_misaligned(req_size, bus.addr[1:0]);

    dmem_lane #(.DW(DW)) u_lane (
        .size       (size_q),
        .uns        (uns_q),
        .offset     (off_q),
        .rd_word    (bus.mem_rd),
        .merge_word (merge_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // State register and request/merge/result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            size_q  <= SZ_WORD;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            wdata_q <= '0;
            err_q   <= 1'b0;
            merge_q <= '0;
            rdata_q <= '0;
            mem_a_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values, independent of statement order.
            state_q <= state_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            mem_a_q <= mem_a_d;
        end
    end

    // Next-state logic: accept in IDLE, then walk the access sequence.
    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        mem_a_d = mem_a_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    size_d  = req_size;
                    uns_d   = bus.uns;
                    off_d   = bus.addr[1:0];
                    wdata_d = bus.wdata;
                    err_d   = req_err;
                    if (req_err) begin
                        state_d = ST_RESP;
                    end else begin
                        // The memory address only moves for accesses that reach memory.
                        mem_a_d = {bus.addr[AW-1:2], 2'b00};
                        if (!bus.wr)                  state_d = ST_LOAD;
                        else if (req_size == SZ_WORD) state_d = ST_STORE;
                        else                          state_d = ST_RMW_RD;
                    end
                end
            end
            ST_LOAD: begin
                rdata_d = load_data;
                state_d = ST_RESP;
            end
            ST_STORE:  state_d = ST_RESP;
            ST_RMW_RD: begin
                merge_d = bus.mem_rd;
                state_d = ST_RMW_WR;
            end
            ST_RMW_WR: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs decode straight from the state so reset removes a pending write at once.
    assign writing        = (state_q == ST_STORE) || (state_q == ST_RMW_WR);
    assign bus.ready      = (state_q == ST_IDLE);
    assign bus.done       = (state_q == ST_RESP);
    assign bus.misaligned = (state_q == ST_RESP) && err_q;
    assign bus.rdata      = rdata_q;
    assign bus.mem_we     = writing;
    assign bus.mem_a      = mem_a_q;
    assign bus.mem_wd     = writing ? store_word : '0;
endmodule
